shunting_yard: RTL and testbench

SHUNTING_YARD -- requirements
Module: shunting_yard

---
 rtl/shunting_yard.sv | 170 +++++++++++++++++
 tb/tb_shunting_yard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shunting_yard.sv
// Streaming infix-to-postfix converter (Dijkstra shunting-yard).
// Number/operator tokens enter one at a time; RPN tokens leave through a registered output slot.
module shunting_yard #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [1:0]        IN_KIND,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OUT_KIND,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              DONE,
   output logic              ERR,
   output logic              BUSY
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      ACCEPT, EMIT, POP_PREC, PUSH_OP, POP_PAREN, FLUSH, DONE_ST, ERROR
   } state_t;

   state_t            state, nxt;
   logic [7:0]        stk [DEPTH];
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  top_idx, wr_idx;
   logic [7:0]        top, pend, in_op, push_data;
   logic              push, pop, load, load_kind, pend_we;
   logic              in_fire, out_fire, can_load, full, empty;
   logic [DATA_W-1:0] load_data;

   function automatic logic is_arith(input logic [7:0] c);
      return (c == "+") || (c == "-") || (c == "*") || (c == "/");
   endfunction

   // '(' ranks lowest so an incoming operator never pops past it.
   function automatic logic [1:0] prec(input logic [7:0] c);
      case (c)
         "+", "-": prec = 2'd1;
         "*", "/": prec = 2'd2;
         default:  prec = 2'd0;
      endcase
   endfunction

   assign in_op    = IN_DATA[7:0];
   assign top_idx  = IDX_W'(cnt - CNT_W'(1));
   assign wr_idx   = IDX_W'(cnt);
   assign top      = stk[top_idx];
   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign out_fire = OUT_VALID && OUT_READY;
   assign can_load = !OUT_VALID || OUT_READY;
   assign in_fire  = IN_READY && IN_VALID;
   assign DONE     = (state == DONE_ST);
   assign ERR      = (state == ERROR);
   assign BUSY     = (state != ACCEPT);

   always_ff @(posedge CLK) begin
      if (RST) state <= ACCEPT;
      else     state <= nxt;
   end

   // Popping states only act when the output slot is free or draining this cycle,
   // so every popped operator is handed over before the state moves on.
   always_comb begin
      nxt       = state;
      IN_READY  = (state == ACCEPT) && !OUT_VALID;
      push      = 1'b0;
      push_data = in_op;
      pop       = 1'b0;
      load      = 1'b0;
      load_kind = 1'b1;
      load_data = DATA_W'(top);
      pend_we   = 1'b0;
      case (state)
         ACCEPT: if (in_fire) begin
            case (IN_KIND)
               2'd0: begin
                  load      = 1'b1;
                  load_kind = 1'b0;
                  load_data = IN_DATA;
                  nxt       = EMIT;
               end
               2'd1: begin
                  if (in_op == "(") begin
                     if (full) nxt = ERROR;
                     else      push = 1'b1;
                  end else if (in_op == ")") begin
                     nxt = POP_PAREN;
                  end else if (is_arith(in_op)) begin
                     pend_we = 1'b1;
                     nxt     = POP_PREC;
                  end else begin
                     nxt = ERROR;
                  end
               end
               2'd2:    nxt = FLUSH;
               default: nxt = ERROR;
            endcase
         end
         EMIT: if (out_fire) nxt = ACCEPT;
         POP_PREC: if (can_load) begin
            if (!empty && prec(top) >= prec(pend)) begin
               load = 1'b1;
               pop  = 1'b1;
            end else begin
               nxt = PUSH_OP;
            end
         end
         PUSH_OP: begin
            if (full) nxt = ERROR;
            else begin
               push      = 1'b1;
               push_data = pend;
               nxt       = ACCEPT;
            end
         end
         POP_PAREN: if (can_load) begin
            if (empty) nxt = ERROR;
            else if (top == "(") begin
               pop = 1'b1;
               nxt = ACCEPT;
            end else begin
               load = 1'b1;
               pop  = 1'b1;
            end
         end
         FLUSH: if (can_load) begin
            if (empty)             nxt = DONE_ST;
            else if (top == "(")   nxt = ERROR;
            else begin
               load = 1'b1;
               pop  = 1'b1;
            end
         end
         DONE_ST: nxt = ACCEPT;
         default: nxt = ERROR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt       <= '0;
         OUT_VALID <= 1'b0;
         OUT_KIND  <= 1'b0;
         OUT_DATA  <= '0;
      end else begin
         if (nxt == ERROR) OUT_VALID <= 1'b0;
         else if (load) begin
            OUT_VALID <= 1'b1;
            OUT_KIND  <= load_kind;
            OUT_DATA  <= load_data;
         end else if (out_fire) begin
            OUT_VALID <= 1'b0;
         end
         if (push)     cnt <= cnt + CNT_W'(1);
         else if (pop) cnt <= cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push)    stk[wr_idx] <= push_data;
      if (pend_we) pend        <= in_op;
   end
endmodule

// File: tb/tb_shunting_yard.sv
// Bench for shunting_yard: directed expressions plus random token streams,
// checked against a queue-based infix-to-RPN reference model.
module tb_shunting_yard;
   localparam int DW = 12;

   typedef struct packed {
      logic [1:0]    kind;
      logic [DW-1:0] data;
   } tok_t;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready, out_kind;
   logic          done, err, busy;
   logic [1:0]    in_kind;
   logic [DW-1:0] in_data, out_data;

   logic          s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_kind;
   logic          s_done, s_err, s_busy;
   logic [1:0]    s_in_kind;
   logic [7:0]    s_in_data, s_out_data;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;
   int done_cnt = 0;
   int stall = 0;
   bit holding = 0;
   logic [DW:0] held_tok;
   logic [DW:0] got_q[$];
   logic [DW:0] exp_q[$];
   tok_t        tok_q[$];
   bit          exp_err, exp_done;
   int          last_idx;

   always #5 clk = ~clk;

   shunting_yard #(.DATA_W(DW), .DEPTH(16)) u_dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_KIND(in_kind), .IN_DATA(in_data), .OUT_VALID(out_valid),
      .OUT_READY(out_ready), .OUT_KIND(out_kind), .OUT_DATA(out_data),
      .DONE(done), .ERR(err), .BUSY(busy));

   shunting_yard #(.DATA_W(8), .DEPTH(2)) u_small (
      .CLK(clk), .RST(s_rst), .IN_VALID(s_in_valid), .IN_READY(s_in_ready),
      .IN_KIND(s_in_kind), .IN_DATA(s_in_data), .OUT_VALID(s_out_valid),
      .OUT_READY(1'b1), .OUT_KIND(s_out_kind), .OUT_DATA(s_out_data),
      .DONE(s_done), .ERR(s_err), .BUSY(s_busy));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output-side driver and monitor: choose OUT_READY, then record a handshake.
   always @(negedge clk) begin
      if (rst) begin
         holding = 0;
         stall   = 0;
      end else begin
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: if (out_valid && stall < 5) begin out_ready = 1'b0; stall++; end
               else out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
         if (holding) check("hold_stable", 32'({out_valid, out_kind, out_data}), 32'({1'b1, held_tok}));
         if (out_valid && out_ready) begin
            got_q.push_back({out_kind, out_data});
            holding = 0;
            stall   = 0;
         end else if (out_valid) begin
            holding  = 1;
            held_tok = {out_kind, out_data};
         end else begin
            holding = 0;
         end
         check("ready_excl", 32'(in_ready & out_valid), 32'd0);
         if (done) done_cnt++;
      end
   end

   function automatic int rank(input logic [7:0] c);
      if (c == "+" || c == "-") return 1;
      if (c == "*" || c == "/") return 2;
      return 0;
   endfunction

   // Reference: classic shunting-yard over queues; stops at END or at the first error.
   task automatic model(input int depth);
      logic [7:0] stk[$];
      logic [7:0] c, t;
      bit bad, found;
      exp_q.delete();
      exp_err  = 0;
      exp_done = 0;
      last_idx = tok_q.size() - 1;
      for (int i = 0; i < tok_q.size(); i++) begin
         c   = tok_q[i].data[7:0];
         bad = 0;
         case (tok_q[i].kind)
            2'd0: exp_q.push_back({1'b0, tok_q[i].data});
            2'd1: begin
               if (c == "(") begin
                  if (stk.size() == depth) bad = 1; else stk.push_back(c);
               end else if (c == ")") begin
                  found = 0;
                  while (!found && !bad) begin
                     if (stk.size() == 0) bad = 1;
                     else begin
                        t = stk.pop_back();
                        if (t == "(") found = 1; else exp_q.push_back({1'b1, 4'h0, t});
                     end
                  end
               end else if (rank(c) > 0) begin
                  while (stk.size() > 0 && rank(stk[stk.size()-1]) >= rank(c))
                     exp_q.push_back({1'b1, 4'h0, stk.pop_back()});
                  if (stk.size() == depth) bad = 1; else stk.push_back(c);
               end else begin
                  bad = 1;
               end
            end
            2'd2: begin
               while (stk.size() > 0 && !bad) begin
                  t = stk.pop_back();
                  if (t == "(") bad = 1; else exp_q.push_back({1'b1, 4'h0, t});
               end
               if (!bad) exp_done = 1;
            end
            default: bad = 1;
         endcase
         if (bad) begin exp_err = 1; last_idx = i; break; end
         if (exp_done) begin last_idx = i; break; end
      end
   endtask

   task automatic num(input int v);
      tok_q.push_back({2'd0, DW'(v)});
   endtask

   task automatic op(input logic [7:0] c);
      tok_q.push_back({2'd1, 4'($urandom_range(0, 15)), c});
   endtask

   task automatic endt();
      tok_q.push_back({2'd2, DW'(0)});
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_q.delete();
      done_cnt = 0;
   endtask

   task automatic send(input tok_t t);
      int n = 0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_kind  = t.kind;
      in_data  = t.data;
      while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
      check("send_accept", 32'(n < 1000), 32'd1);
      if (n < 1000) begin @(posedge clk); #1; end
      in_valid = 1'b0;
   endtask

   task automatic run_expr(input string tag);
      int n = 0;
      model(16);
      got_q.delete();
      done_cnt = 0;
      for (int i = 0; i <= last_idx; i++) send(tok_q[i]);
      do begin @(posedge clk); #1; n++; end
      while (((busy && !err) || out_valid) && n < 3000);
      check({tag, "_settle"}, 32'(n < 3000), 32'd1);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check($sformatf("%s_tok%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      if (exp_err) do_reset();
   endtask

   initial begin
      in_kind = 2'd0; in_data = '0; out_ready = 1'b1;
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_kind = 2'd1; s_in_data = "(";
      do_reset();
      check("rst_outs", 32'({in_ready, out_valid, out_kind, out_data, done, err, busy}),
            32'({1'b1, 1'b0, 1'b0, DW'(0), 1'b0, 1'b0, 1'b0}));

      // 3 + 4 * 2 END -> 3 4 2 * +
      tok_q.delete(); num(3); op("+"); num(4); op("*"); num(2); endt();
      run_expr("prec");
      check("prec_tok3_lit", 32'(got_q.size() > 3 ? got_q[3] : '0), 32'({1'b1, DW'("*")}));
      check("prec_tok4_lit", 32'(got_q.size() > 4 ? got_q[4] : '0), 32'({1'b1, DW'("+")}));

      tok_q.delete(); op("("); num(1); op("+"); num(2); op(")"); op("*"); num(3); endt();
      run_expr("paren");
      tok_q.delete(); num(8); op("-"); num(3); op("-"); num(2); endt();
      run_expr("lassoc");
      check("lassoc_tok2_lit", 32'(got_q.size() > 2 ? got_q[2] : '0), 32'({1'b1, DW'("-")}));

      ready_mode = 2;
      tok_q.delete(); num(3); op("+"); num(4); endt();
      run_expr("stall");
      ready_mode = 0;

      tok_q.delete(); num(1); op(")");
      run_expr("lone_close");
      tok_q.delete(); op("("); num(1); endt();
      run_expr("open_flush");
      tok_q.delete(); num(5); op("^");
      run_expr("bad_op");
      tok_q.delete(); num(5); tok_q.push_back({2'd3, DW'(0)});
      run_expr("kind3");

      // Empty expression: DONE exactly two cycles after acceptance.
      tok_q.delete(); endt();
      send(tok_q[0]);
      check("empty_d1", 32'(done), 32'd0);
      @(posedge clk); #1 check("empty_d2", 32'(done), 32'd1);
      @(posedge clk); #1 check("empty_d3", 32'({done, busy}), 32'd0);
      check("empty_out", 32'(got_q.size()), 32'd0);

      // Reset with an output token pending drops it.
      ready_mode = 3;
      tok_q.delete(); num(9);
      send(tok_q[0]);
      repeat (3) @(posedge clk);
      #1 check("pend_valid", 32'(out_valid), 32'd1);
      do_reset();
      check("pend_drop", 32'({out_valid, out_data}), 32'd0);
      ready_mode = 0;
      @(posedge clk); #1 check("pend_nolog", 32'(got_q.size()), 32'd0);

      for (int e = 0; e < 40; e++) begin
         int len, r;
         ready_mode = $urandom_range(0, 1);
         tok_q.delete();
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      num($urandom_range(0, 4095));
            else if (r < 70) case ($urandom_range(0, 3))
                                0: op("+"); 1: op("-"); 2: op("*"); default: op("/");
                             endcase
            else if (r < 82) op("(");
            else if (r < 94) op(")");
            else if (r < 97) op(8'($urandom_range(0, 39)));
            else             tok_q.push_back({2'd3, DW'($urandom)});
         end
         endt();
         run_expr($sformatf("rnd%0d", e));
      end

      // Two-entry stack overflows on the third '('.
      @(posedge clk); #1 s_rst = 1'b0;
      check("s_rst_outs", 32'({s_in_ready, s_out_valid, s_out_kind, s_out_data, s_done, s_err, s_busy}),
            32'({1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}));
      for (int p = 0; p < 3; p++) begin
         int n = 0;
         s_in_valid = 1'b1;
         while (!s_in_ready && n < 50) begin @(posedge clk); #1; n++; end
         check($sformatf("s_push%0d_ready", p), 32'(n < 50), 32'd1);
         @(posedge clk); #1 s_in_valid = 1'b0;
         check($sformatf("s_push%0d_err", p), 32'(s_err), 32'(p == 2));
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1 check("s_err_hold", 32'({s_in_ready, s_err, s_busy, s_done, s_out_valid}), 32'b01100);
      end
      s_rst = 1'b1;
      @(posedge clk); #1 s_rst = 1'b0;
      check("s_rst_ready", 32'({s_in_ready, s_err}), 32'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
